// File: rtl/pkt_readback_if.sv
// Host bus and fabric push/full signals of the three-port readback queue.
interface pkt_readback_if;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [3:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_wren1;
    logic        out_wren2;
    logic        out_wren3;
    logic [31:0] out_data1;
    logic [31:0] out_data2;
    logic [31:0] out_data3;
    logic        out_full1;
    logic        out_full2;
    logic        out_full3;

    modport master (
        output chipselect, read, write, address, writedata,
        output out_wren1, out_wren2, out_wren3,
        output out_data1, out_data2, out_data3,
        input  readdata, out_full1, out_full2, out_full3
    );

    modport slave (
        input  chipselect, read, write, address, writedata,
        input  out_wren1, out_wren2, out_wren3,
        input  out_data1, out_data2, out_data3,
        output readdata, out_full1, out_full2, out_full3
    );
endinterface

// File: rtl/pkt_readback.sv
// Three fabric-fed circular queues drained by host reads.
// Status at address 0, drop counters at 4, flush by write to 7.
module pkt_readback #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input logic           clk,
    input logic           reset,
    pkt_readback_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   mem  [3][DEPTH];
    logic [AW-1:0] wptr [3];
    logic [AW-1:0] rptr [3];
    logic [CW-1:0] cnt  [3];
    logic [7:0]    drop [3];
    logic [31:0]   wdat [3];
    logic [2:0]    uf;
    logic [2:0]    wren;
    logic [2:0]    full;
    logic [2:0]    empty;
    logic [2:0]    sel;
    logic [2:0]    pop;
    logic [2:0]    push;
    logic [2:0]    drp;
    logic [2:0]    ufe;
    logic [2:0]    flush;
    logic          rd;
    logic          wr;
    logic          stat_rd;
    logic          drop_rd;
    logic [31:0]   status;
    logic [3*CW+40:0] status_w;
    logic          unused;

    assign wren    = {bus.out_wren3, bus.out_wren2, bus.out_wren1};
    assign wdat[0] = bus.out_data1;
    assign wdat[1] = bus.out_data2;
    assign wdat[2] = bus.out_data3;

    assign rd      = bus.chipselect && bus.read;
    assign wr      = bus.chipselect && bus.write;
    assign stat_rd = rd && (bus.address == 4'd0);
    assign drop_rd = rd && (bus.address == 4'd4);

    always_comb begin
        full  = '0;
        empty = '0;
        sel   = '0;
        pop   = '0;
        ufe   = '0;
        push  = '0;
        drp   = '0;
        flush = '0;
        for (int p = 0; p < 3; p++) begin
            full[p]  = cnt[p] == FULL_CNT;
            empty[p] = cnt[p] == '0;
            sel[p]   = rd && (bus.address == 4'(p + 1));
            flush[p] = wr && (bus.address == 4'd7)
                       && bus.writedata[p];
            pop[p]   = sel[p] && !empty[p];
            // an empty queue never bypasses a same-cycle push
            ufe[p]   = sel[p] && empty[p];
            push[p]  = wren[p] && (!full[p] || pop[p])
                       && !flush[p];
            drp[p]   = wren[p] && full[p] && !pop[p]
                       && !flush[p];
        end
    end

    assign status_w = {32'b0, uf, full, empty,
                       cnt[2], cnt[1], cnt[0]};
    assign status   = status_w[31:0];
    assign unused   = ^{bus.writedata[31:3],
                        status_w[3*CW+40:32]};

    assign bus.out_full1 = full[0];
    assign bus.out_full2 = full[1];
    assign bus.out_full3 = full[2];

    always_ff @(posedge clk) begin
        for (int p = 0; p < 3; p++) begin
            if (push[p]) mem[p][wptr[p]] <= wdat[p];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < 3; p++) begin
                wptr[p] <= '0;
                rptr[p] <= '0;
                cnt[p]  <= '0;
                drop[p] <= '0;
            end
            uf           <= '0;
            bus.readdata <= '0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (flush[p]) begin
                    wptr[p] <= '0;
                    rptr[p] <= '0;
                    cnt[p]  <= '0;
                end else begin
                    if (push[p]) wptr[p] <= wptr[p] + AW'(1);
                    if (pop[p])  rptr[p] <= rptr[p] + AW'(1);
                    if (push[p] && !pop[p])
                        cnt[p] <= cnt[p] + CW'(1);
                    else if (pop[p] && !push[p])
                        cnt[p] <= cnt[p] - CW'(1);
                end
                if (drop_rd)
                    drop[p] <= drp[p] ? 8'd1 : 8'd0;
                else if (drp[p] && drop[p] != 8'hff)
                    drop[p] <= drop[p] + 8'd1;
            end
            uf <= (stat_rd ? 3'b000 : uf) | ufe;
            if (rd) begin
                unique case (1'b1)
                    stat_rd: bus.readdata <= status;
                    pop[0]:  bus.readdata <= mem[0][rptr[0]];
                    pop[1]:  bus.readdata <= mem[1][rptr[1]];
                    pop[2]:  bus.readdata <= mem[2][rptr[2]];
                    drop_rd: bus.readdata <= {8'h00, drop[2],
                                              drop[1], drop[0]};
                    default: bus.readdata <= '0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pkt_readback.sv
// Directed bench for pkt_readback: expected read data is queued
// at issue time and checked by a monitor one cycle later.
module tb_pkt_readback;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rd_d;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    string nm_q[$];
    logic [31:0] mq[$];

    pkt_readback_if bus();

    pkt_readback dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_d <= 1'b0;
        else rd_d <= bus.chipselect && bus.read;
    end

    always @(negedge clk) begin
        if (rd_d) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_read: got %h, want none",
                         bus.readdata);
            end else begin
                check(nm_q.pop_front(), bus.readdata,
                      exp_q.pop_front());
            end
        end
    end

    task automatic op(input logic [2:0] we, input logic [31:0] d,
                      input logic r, input logic [3:0] a,
                      input logic [31:0] e, input string nm,
                      input logic w = 1'b0,
                      input logic [31:0] wd = 32'h0);
        bus.out_wren1  = we[0];
        bus.out_wren2  = we[1];
        bus.out_wren3  = we[2];
        bus.out_data1  = d;
        bus.out_data2  = d;
        bus.out_data3  = d;
        bus.chipselect = r | w;
        bus.read       = r;
        bus.write      = w;
        bus.address    = a;
        bus.writedata  = wd;
        if (r) begin
            exp_q.push_back(e);
            nm_q.push_back(nm);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        op(3'b000, 32'h0, 1'b0, 4'd0, 32'h0, "");
    endtask

    task automatic push(input int p, input logic [31:0] d);
        op(3'(1 << (p - 1)), d, 1'b0, 4'd0, 32'h0, "");
    endtask

    task automatic rdq(input logic [3:0] a, input logic [31:0] e,
                       input string nm);
        op(3'b000, 32'h0, 1'b1, a, e, nm);
    endtask

    initial begin
        idle();
        #1;
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_full", {29'h0, bus.out_full3, bus.out_full2,
                           bus.out_full1}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic ordering on port 1
        push(1, 32'h1111_1111);
        push(1, 32'h2222_2222);
        rdq(4'd0, 32'h0003_0002, "stat_two");
        rdq(4'd1, 32'h1111_1111, "p1_first");
        rdq(4'd1, 32'h2222_2222, "p1_second");
        rdq(4'd0, 32'h0003_8000, "stat_empty");

        // fill port 2 past capacity
        for (int i = 0; i < 17; i++) begin
            push(2, 32'hB000_0000 + i);
            if (i == 14) check("full2_at15", 32'(bus.out_full2), 0);
            if (i == 15) check("full2_at16", 32'(bus.out_full2), 1);
        end
        check("full2_at17", 32'(bus.out_full2), 1);
        rdq(4'd0, 32'h000A_8200, "stat_full2");
        rdq(4'd4, 32'h0000_0100, "drop_one");
        rdq(4'd4, 32'h0000_0000, "drop_clr");
        for (int i = 0; i < 16; i++)
            rdq(4'd2, 32'hB000_0000 + i, "p2_drain");
        rdq(4'd2, 32'h0, "p2_under");
        rdq(4'd0, 32'h0043_8000, "stat_uf2");
        rdq(4'd0, 32'h0003_8000, "stat_uf2_clr");

        // underflow sticky on port 3
        rdq(4'd3, 32'h0, "p3_under");
        rdq(4'd0, 32'h0083_8000, "stat_uf3");
        rdq(4'd0, 32'h0003_8000, "stat_uf3_clr");

        // full port 1 with simultaneous push/pop and wrap
        for (int i = 0; i < 16; i++) begin
            push(1, 32'hA000_0000 + i);
            mq.push_back(32'hA000_0000 + i);
        end
        check("full1", 32'(bus.out_full1), 1);
        for (int i = 0; i < 40; i++) begin
            op(3'b001, 32'hA100_0000 + i, 1'b1, 4'd1,
               mq.pop_front(), "p1_pushpop");
            mq.push_back(32'hA100_0000 + i);
        end
        rdq(4'd0, 32'h0007_0010, "stat_full1");
        rdq(4'd4, 32'h0, "drop_none");
        for (int i = 0; i < 16; i++)
            rdq(4'd1, mq.pop_front(), "p1_wrap_drain");

        // push+pop on an empty port: no bypass
        op(3'b100, 32'h3333_3333, 1'b1, 4'd3, 32'h0, "p3_nobypass");
        rdq(4'd0, 32'h0081_8400, "stat_p3_one");
        rdq(4'd3, 32'h3333_3333, "p3_after");

        // flush ports 1 and 3
        push(1, 32'h4000_0001);
        push(1, 32'h4000_0002);
        push(2, 32'h5000_0001);
        push(3, 32'h6000_0001);
        op(3'b110, 32'h5000_0002, 1'b0, 4'd7, 32'h0, "",
           1'b1, 32'h0000_0005);
        rdq(4'd0, 32'h0002_8040, "stat_flush");
        rdq(4'd4, 32'h0, "drop_flush");
        rdq(4'd2, 32'h5000_0001, "p2_keep1");
        rdq(4'd2, 32'h5000_0002, "p2_keep2");

        // unmapped addresses
        push(1, 32'hD100_00D1);
        op(3'b000, 32'h0, 1'b0, 4'd6, 32'h0, "", 1'b1, 32'hFFFF_FFFF);
        rdq(4'd9, 32'h0, "addr9");
        rdq(4'd1, 32'hD100_00D1, "p1_unmapped");

        // reset with queues part-full
        push(1, 32'h7000_0001);
        push(2, 32'h7000_0002);
        push(2, 32'h7000_0003);
        for (int i = 0; i < 16; i++) push(3, 32'h7100_0000 + i);
        check("full3", 32'(bus.out_full3), 1);
        rdq(4'd0, 32'h0010_4041, "stat_prereset");
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_readdata", bus.readdata, 32'h0);
        check("midrst_full3", 32'(bus.out_full3), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rdq(4'd0, 32'h0003_8000, "stat_postreset");
        push(1, 32'hC0FF_EE01);
        rdq(4'd1, 32'hC0FF_EE01, "p1_postreset");
        rdq(4'd1, 32'h0, "p1_post_empty");
        idle();
        idle();
        check("pending_reads", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
